// File: rtl/rgb_pwm_ctrl.sv
// rgb_pwm_ctrl: N-channel PWM LED driver with double-buffered duty and a built-in test sequence.
// Optional define RGB_PWM_FADE_EN: active duty ramps one LSB per period toward the shadow value.
module rgb_pwm_ctrl #(
  parameter int unsigned CHANNELS     = 3,
  parameter int unsigned PWM_W        = 8,
  parameter int unsigned PRESC_DIV    = 4,
  parameter int unsigned TEST_PERIODS = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      test_mode,
  input  logic [CHANNELS*PWM_W-1:0] duty_in,
  input  logic                      duty_we,
  output logic [CHANNELS-1:0]       led,
  output logic                      period_end
);

  localparam int unsigned PRESC_W = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam int unsigned DWELL_W = $clog2(TEST_PERIODS + 1);
  localparam int unsigned IDX_W   = $clog2(CHANNELS + 1);
  localparam logic [PWM_W-1:0] CNT_MAX = '1;

  typedef enum logic {NORMAL, STEP} state_t;

  logic [PRESC_W-1:0] presc;
  logic [PWM_W-1:0]   cnt;
  logic [PWM_W-1:0]   shadow [CHANNELS];
  logic [PWM_W-1:0]   active [CHANNELS];
  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [DWELL_W-1:0] dwell, dwell_nxt;
  logic               tick_c, wrap_c;
  logic [CHANNELS-1:0] led_nxt_c;

  assign tick_c = (presc == PRESC_W'(PRESC_DIV - 1));
  assign wrap_c = tick_c && (cnt == CNT_MAX);

  // Prescaler, PWM counter and period marker run in every mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc      <= '0;
      cnt        <= '0;
      period_end <= 1'b0;
    end else begin
      presc      <= tick_c ? '0 : presc + PRESC_W'(1);
      if (tick_c) cnt <= cnt + PWM_W'(1);
      period_end <= wrap_c;
    end
  end

`ifdef RGB_PWM_FADE_EN
  function automatic logic [PWM_W-1:0] fade_step(input logic [PWM_W-1:0] cur,
                                                 input logic [PWM_W-1:0] tgt);
    logic [PWM_W-1:0] res;
    res = cur;
    if (cur < tgt)      res = cur + PWM_W'(1);
    else if (cur > tgt) res = cur - PWM_W'(1);
    return res;
  endfunction
`endif

  // Active duty samples the pre-write shadow at the wrap, so a coinciding write lands one period later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (duty_we) shadow[i] <= duty_in[i*PWM_W +: PWM_W];
`ifdef RGB_PWM_FADE_EN
        if (wrap_c) active[i] <= fade_step(active[i], shadow[i]);
`else
        if (wrap_c) active[i] <= shadow[i];
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= NORMAL;
      idx   <= '0;
      dwell <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      dwell <= dwell_nxt;
    end
  end

  // Test sequencer: one-hot per channel, then all-on, each held TEST_PERIODS wraps.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    dwell_nxt = dwell;
    unique case (state)
      NORMAL: begin
        if (test_mode) begin
          state_nxt = STEP;
          idx_nxt   = '0;
          dwell_nxt = '0;
        end
      end
      STEP: begin
        if (!test_mode) begin
          state_nxt = NORMAL;
          idx_nxt   = '0;
          dwell_nxt = '0;
        end else if (wrap_c) begin
          if (dwell == DWELL_W'(TEST_PERIODS - 1)) begin
            dwell_nxt = '0;
            idx_nxt   = (idx == IDX_W'(CHANNELS)) ? '0 : idx + IDX_W'(1);
          end else begin
            dwell_nxt = dwell + DWELL_W'(1);
          end
        end
      end
      default: state_nxt = NORMAL;
    endcase
  end

  always_comb begin
    led_nxt_c = '0;
    if (state == STEP) begin
      if (idx == IDX_W'(CHANNELS)) led_nxt_c = '1;
      else                         led_nxt_c = CHANNELS'(1) << idx;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) led_nxt_c[i] = (cnt < active[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) led <= '0;
    else     led <= led_nxt_c;
  end

endmodule

// File: tb/tb_rgb_pwm_ctrl.sv
// tb_rgb_pwm_ctrl: two instances (prescaler 1 and 4) checked cycle by cycle against an
// arithmetic model of cnt/period position derived from the edge count since reset release.
module tb_rgb_pwm_ctrl;

  localparam int CH  = 3;
  localparam int W   = 4;
  localparam int TP  = 2;
  localparam int P2  = 4;
  localparam int PER = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            test_mode = 1'b0;
  logic            duty_we = 1'b0;
  logic [CH*W-1:0] duty_in = '0;
  logic [CH-1:0]   led1, led2;
  logic            pe1, pe2;

  int total = 0;
  int bad   = 0;
  int k = 0, k0 = 0, last_pe2 = 0;
  bit tm_prev = 1'b0, clean1 = 1'b0, clean2 = 1'b0;
  int sh[CH], act1[CH], act2[CH], on1[CH], on2[CH];

  always #5 clk = ~clk;

  rgb_pwm_ctrl #(.CHANNELS(CH), .PWM_W(W), .PRESC_DIV(1), .TEST_PERIODS(TP)) u_dut1 (
    .clk(clk), .rst(rst), .test_mode(test_mode), .duty_in(duty_in),
    .duty_we(duty_we), .led(led1), .period_end(pe1));

  rgb_pwm_ctrl #(.CHANNELS(CH), .PWM_W(W), .PRESC_DIV(P2), .TEST_PERIODS(TP)) u_dut2 (
    .clk(clk), .rst(rst), .test_mode(1'b0), .duty_in(duty_in),
    .duty_we(duty_we), .led(led2), .period_end(pe2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output after edge kk reflects the counter value held before that edge.
  function automatic logic [CH-1:0] pwm_exp(input int kk, input int p, input int act[CH]);
    logic [CH-1:0] r;
    int c;
    c = ((kk - 1) / p) % PER;
    for (int i = 0; i < CH; i++) r[i] = (c < act[i]);
    return r;
  endfunction

  function automatic logic [CH-1:0] test_exp(input int kk, input int kstart);
    logic [CH-1:0] r;
    int idx;
    idx = ((((kk - 1) / PER) - (kstart / PER)) / TP) % (CH + 1);
    r = (idx == CH) ? '1 : CH'(1 << idx);
    return r;
  endfunction

  function automatic int next_active(input int cur, input int tgt);
`ifdef RGB_PWM_FADE_EN
    return (cur < tgt) ? cur + 1 : (cur > tgt) ? cur - 1 : cur;
`else
    return tgt;
`endif
  endfunction

  task automatic cyc();
    logic [CH-1:0] e1, e2;
    bit w1, w2;
    @(posedge clk);
    k++;
    e1 = tm_prev ? test_exp(k, k0) : pwm_exp(k, 1, act1);
    e2 = pwm_exp(k, P2, act2);
    w1 = (k % PER) == 0;
    w2 = (k % (PER * P2)) == 0;
    if (tm_prev) clean1 = 1'b0;
    #1;
    chk("led1", led1, e1);
    chk("pe1", pe1, w1);
    chk("led2", led2, e2);
    chk("pe2", pe2, w2);
    if (pe2 === 1'b1) begin
      if (last_pe2 > 0) chk("pe2_spacing", k - last_pe2, PER * P2);
      last_pe2 = k;
    end
    for (int i = 0; i < CH; i++) begin
      on1[i] += int'(led1[i]);
      on2[i] += int'(led2[i]);
    end
    if (w1) begin
      if (clean1) for (int i = 0; i < CH; i++) chk("on_count1", on1[i], act1[i]);
      for (int i = 0; i < CH; i++) begin
        act1[i] = next_active(act1[i], sh[i]);
        on1[i]  = 0;
      end
      clean1 = 1'b1;
    end
    if (w2) begin
      if (clean2) for (int i = 0; i < CH; i++) chk("on_count2", on2[i], P2 * act2[i]);
      for (int i = 0; i < CH; i++) begin
        act2[i] = next_active(act2[i], sh[i]);
        on2[i]  = 0;
      end
      clean2 = 1'b1;
    end
    if (duty_we) for (int i = 0; i < CH; i++) sh[i] = int'(duty_in[i*W +: W]);
    if (test_mode && !tm_prev) k0 = k;
    tm_prev = test_mode;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
    k = 0; k0 = 0; last_pe2 = 0;
    tm_prev = 1'b0; clean1 = 1'b1; clean2 = 1'b1;
    for (int i = 0; i < CH; i++) begin
      sh[i] = 0; act1[i] = 0; act2[i] = 0; on1[i] = 0; on2[i] = 0;
    end
  endtask

  task automatic write_duty(input int d0, input int d1, input int d2);
    duty_in = {W'(d2), W'(d1), W'(d0)};
    duty_we = 1'b1;
    cyc();
    duty_we = 1'b0;
  endtask

  initial begin
    #2;
    repeat (3) begin
      @(negedge clk);
      chk("reset_led1", led1, 0);
      chk("reset_pe1", pe1, 0);
      chk("reset_led2", led2, 0);
    end
    release_reset();
    repeat (3 * PER) cyc();

    write_duty(0, 5, 15);
    repeat (3 * PER) cyc();

    // Collision: shadow ch0 = 3, then write 9 on the exact wrap edge.
    repeat (5) cyc();
    write_duty(3, 5, 15);
    while (((k + 1) % PER) != 0) cyc();
    write_duty(9, 5, 15);
    repeat (3 * PER) cyc();

    write_duty(8, 8, 8);
    repeat (4 * PER * P2) cyc();

    repeat (12) begin
      repeat ($urandom_range(40, 1)) cyc();
      write_duty($urandom_range(15), $urandom_range(15), $urandom_range(15));
    end
    repeat (2 * PER) cyc();

    repeat ($urandom_range(20, 1)) cyc();
    test_mode = 1'b1;
    repeat ((CH + 1) * TP * PER + 40) cyc();
    test_mode = 1'b0;
    repeat (2 * PER) cyc();

    repeat ($urandom_range(30, 1)) cyc();
    test_mode = 1'b1;
    repeat ($urandom_range(60, 20)) cyc();
    write_duty($urandom_range(15), $urandom_range(15), $urandom_range(15));
    repeat ($urandom_range(80, 20)) cyc();
    test_mode = 1'b0;
    repeat (3 * PER) cyc();

    // Asynchronous reset in the middle of a cycle while LEDs are lit.
    write_duty(15, 15, 15);
    repeat (16 * PER) cyc();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_led1", led1, 0);
    chk("arst_pe1", pe1, 0);
    chk("arst_led2", led2, 0);
    chk("arst_pe2", pe2, 0);
    repeat (2) begin
      @(negedge clk);
      chk("arst_hold_led1", led1, 0);
    end
    release_reset();
    repeat (3 * PER) cyc();
    write_duty(6, 1, 12);
    repeat (3 * PER * P2) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rgb_pwm_ctrl.md
# rgb_pwm_ctrl

Parametrised N-channel PWM LED controller, the successor to the fixed 3-channel RGB wrapper at the top level. It drives `CHANNELS` LED outputs from per-channel `PWM_W`-bit duty registers, with double-buffered updates applied glitch-free at PWM period boundaries. A built-in test mode runs a one-hot channel sequence followed by an all-on step. It sits between the SPI/register logic and the `rgb` pads (via the SB_RGBA_DRV wrapper), clocked from the PLL output.

## Interface
- `CHANNELS`, 3: number of LED outputs (1..8).
- `PWM_W`, 8: duty and PWM counter width (2..12).
- `PRESC_DIV`, 4: clk cycles per PWM counter tick (≥1).
- `TEST_PERIODS`, 64: PWM periods per test-mode step (≥1).

Ports:
- `clk`  in  1: system clock, PLL output.
- `rst`  in  1: asynchronous reset, active-high; all state clears immediately.
- `test_mode`  in  1: 1 = run the test sequence; duty registers are ignored for output but still writable.
- `duty_in`  in  CHANNELS*PWM_W: packed duty values, channel i at `[i*PWM_W +: PWM_W]`.
- `duty_we`  in  1: single-cycle strobe; captures `duty_in` into the shadow registers.
- `led`  out  CHANNELS: registered LED drive, 1 = on.
- `period_end`  out  1: registered one-cycle pulse on each PWM period wrap.

## Operation
- Prescaler counts 0..PRESC_DIV-1. A tick occurs on the cycle it equals PRESC_DIV-1, and the prescaler then wraps to 0. With PRESC_DIV=1, every cycle is a tick.
- PWM counter `cnt` (PWM_W bits) increments on each tick and wraps from 2^PWM_W-1 to 0.
- Wrap event: tick while cnt = 2^PWM_W-1.
  - `period_end` pulses on the next cycle.
  - Active duty registers update.
- Shadow duty: loaded on `duty_we`. If `duty_we` and a wrap event coincide, active takes the OLD shadow, shadow takes the new value, and the new value applies from the following period.
- Normal mode: `led[i]` is registered from (cnt < active[i]).
  - Duty 0 gives always off.
  - Duty 2^PWM_W-1 gives on for (2^PWM_W-1) of 2^PWM_W counts.
  - There is no 100 % state.
- Test FSM states: NORMAL, STEP.
  - NORMAL → STEP when `test_mode`=1. Step index is set to 0 and the dwell counter cleared; this takes effect on the next clock, not at a wrap.
  - In STEP, the dwell counter increments on each wrap event. At TEST_PERIODS it clears and the index advances.
  - Index 0..CHANNELS-1: `led` = one-hot(index), solid (no PWM).
  - Index CHANNELS: `led` = all ones. The index then wraps to 0.
  - STEP → NORMAL when `test_mode`=0. Index and dwell clear. PWM output resumes from current cnt/active with no period restart.
- Prescaler, cnt and the duty logic run continuously in both modes.

## Timing
- Reset values:
  - `led` = 0, `period_end` = 0.
  - Prescaler = 0, cnt = 0.
  - Shadow = 0, active = 0.
  - FSM = NORMAL, index = 0, dwell = 0.
- `led` latency: 1 clk after the cnt/active change. Test pattern appears 2 clk after `test_mode` rises (FSM register, then output register).
- Duty write to visible output: takes effect at the first wrap event after the capture cycle, plus 1 clk.
- `rst` asserted mid-period or mid-test: outputs go to 0 asynchronously. After release, counting restarts at cnt=0 with active=0, so LEDs stay off until a write and a wrap.
- All comparisons are unsigned, PWM_W bits wide. The dwell counter is $clog2(TEST_PERIODS+1) bits wide.

## Configuration
- `RGB_PWM_FADE_EN` defined: on each wrap event, active[i] moves one LSB toward shadow[i] instead of jumping. It holds when equal. Full-scale transitions therefore take up to 2^PWM_W-1 periods. `duty_we` retargets the fade mid-ramp without resetting active.
- Not defined: active[i] is loaded directly from shadow[i] at the wrap (instant update). No fade logic is synthesised.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle with LEDs on → `led`=0 and `period_end`=0 immediately. With no write, `led` stays 0 for 3 full periods after release.
- Duty/PWM (PWM_W=4, PRESC_DIV=1, CHANNELS=3): write duties 0, 5, 15 → from the next period, per 16-cycle period: `led[0]` high 0 cycles, `led[1]` 5, `led[2]` 15. `period_end` pulses every 16 cycles.
- Write/wrap collision: `duty_we` with `duty_in` ch0=9 on the wrap cycle while shadow ch0=3 → the next period shows 3 on-cycles, the period after shows 9.
- Test mode (TEST_PERIODS=2): raise `test_mode` → `led` = 001 after 2 clk, then 010, 100, 111, 001, each held for 2 periods. Dropping `test_mode` returns to PWM output within 2 clk.
- Prescaler (PRESC_DIV=4, PWM_W=4): `period_end` spacing is exactly 64 clk. Duty 8 gives 32 high cycles per period.
- Fade (`RGB_PWM_FADE_EN`, PWM_W=4): from active=0, write 4 → on-counts 1, 2, 3, 4, 4 in successive periods. Writing 2 at count 3 gives 3, 2, 2.
